// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pkg
//  Description : Shared definitions for the call/return sequencer: operation
//                encodings and the sequencer state type.
//  Revision    : 1.0  initial release
// ============================================================================
package seq_pkg;

    // Operation codes presented on the op input
    localparam logic [1:0] OP_SEQ  = 2'b00;
    localparam logic [1:0] OP_JUMP = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    // Sequencer states: RUN accepts operations, RET_WAIT waits one cycle for
    // the external stack to deliver the popped return address.
    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_RET_WAIT = 1'b1
    } seq_state_e;

endpackage : seq_pkg
`default_nettype wire

// File: rtl/call_return_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : call_return_sequencer
//  Description : Program-counter sequencer with CALL/RET support through an
//                external return-address stack.
//  Ports       : clk, reset     - clock, synchronous active-high reset
//                op_valid, op   - operation strobe and code (SEQ/JUMP/CALL/RET)
//                target         - destination address for JUMP and CALL
//                stall          - freezes operation acceptance in RUN
//                err_clr        - clears the sticky overflow/underflow flags
//                stk_rdata      - popped value, valid the cycle after stk_pop
//                pc             - registered program counter
//                stk_push/pop   - stack requests, stk_wdata - pushed address
//                busy           - high while waiting for the return address
//                depth          - occupied stack entries
//                overflow/underflow - sticky error flags
//  Revision    : 1.0  initial release
// ============================================================================
module call_return_sequencer
    import seq_pkg::*;
#(
    parameter int ADDR_W     = 13,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    input  logic [1:0]            op,
    input  logic [ADDR_W-1:0]     target,
    input  logic                  stall,
    input  logic                  err_clr,
    input  logic [ADDR_W-1:0]     stk_rdata,
    output logic [ADDR_W-1:0]     pc,
    output logic                  stk_push,
    output logic                  stk_pop,
    output logic [ADDR_W-1:0]     stk_wdata,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   depth,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [DEPTH_LOG2:0] c_DEPTH_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0]   c_PC_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

    seq_state_e              state_q, state_d;
    logic [ADDR_W-1:0]       pc_q, pc_d;
    logic [DEPTH_LOG2:0]     depth_q, depth_d;
    logic                    overflow_q, overflow_d;
    logic                    underflow_q, underflow_d;

    logic                    w_accept;
    logic                    w_full;
    logic                    w_empty;
    logic [ADDR_W-1:0]       w_pc_inc;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_ovf_set;
    logic                    w_udf_set;

    // Depth never exceeds 2**DEPTH_LOG2, so the MSB alone marks a full stack.
    assign w_full   = depth_q[DEPTH_LOG2];
    assign w_empty  = (depth_q == '0);
    assign w_pc_inc = pc_q + c_PC_ONE;
    assign w_accept = (state_q == ST_RUN) && op_valid && !stall;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        depth_d   = depth_q;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_ovf_set = 1'b0;
        w_udf_set = 1'b0;

        if (state_q == ST_RET_WAIT) begin
            // Stack data is valid now; op_valid and stall are ignored here.
            pc_d    = stk_rdata;
            state_d = ST_RUN;
        end else if (w_accept) begin
            case (op)
                OP_SEQ:  pc_d = w_pc_inc;
                OP_JUMP: pc_d = target;
                OP_CALL: begin
                    if (w_full) begin
                        w_ovf_set = 1'b1;
                        pc_d      = w_pc_inc;
                    end else begin
                        w_push  = 1'b1;
                        pc_d    = target;
                        depth_d = depth_q + c_DEPTH_ONE;
                    end
                end
                default: begin // OP_RET
                    if (w_empty) begin
                        w_udf_set = 1'b1;
                        pc_d      = w_pc_inc;
                    end else begin
                        w_pop   = 1'b1;
                        depth_d = depth_q - c_DEPTH_ONE;
                        state_d = ST_RET_WAIT;
                    end
                end
            endcase
        end

        // A new error event in the clearing cycle keeps the flag set.
        overflow_d  = w_ovf_set | (overflow_q  & ~err_clr);
        underflow_d = w_udf_set | (underflow_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            pc_q        <= '0;
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Strobes are masked by reset so nothing reaches the stack in a reset cycle.
    assign stk_push  = w_push && !reset;
    assign stk_pop   = w_pop  && !reset;
    assign stk_wdata = stk_push ? w_pc_inc : '0;
    assign busy      = (state_q == ST_RET_WAIT) && !reset;
    assign pc        = pc_q;
    assign depth     = depth_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule : call_return_sequencer
`default_nettype wire

// File: tb/tb_call_return_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_call_return_sequencer
//  Description : Self-checking bench for call_return_sequencer with directed
//                scenarios and randomized traffic against a queue-based model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_call_return_sequencer;

    localparam int AW  = 13;
    localparam int DL2 = 3;
    localparam int CAP = 1 << DL2;

    localparam logic [1:0] SEQ  = 2'b00;
    localparam logic [1:0] JUMP = 2'b01;
    localparam logic [1:0] CALL = 2'b10;
    localparam logic [1:0] RET  = 2'b11;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            op_valid = 1'b0;
    logic [1:0]      op = 2'b00;
    logic [AW-1:0]   target = '0;
    logic            stall = 1'b0;
    logic            err_clr = 1'b0;
    logic [AW-1:0]   stk_rdata;
    logic [AW-1:0]   pc;
    logic            stk_push;
    logic            stk_pop;
    logic [AW-1:0]   stk_wdata;
    logic            busy;
    logic [DL2:0]    depth;
    logic            overflow;
    logic            underflow;

    call_return_sequencer #(.ADDR_W(AW), .DEPTH_LOG2(DL2)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op        (op),
        .target    (target),
        .stall     (stall),
        .err_clr   (err_clr),
        .stk_rdata (stk_rdata),
        .pc        (pc),
        .stk_push  (stk_push),
        .stk_pop   (stk_pop),
        .stk_wdata (stk_wdata),
        .busy      (busy),
        .depth     (depth),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    // External stack: registered read, data valid the cycle after a pop.
    logic [AW-1:0] r_mem [0:CAP-1];
    int            r_sp;
    logic [AW-1:0] r_rdata;
    assign stk_rdata = r_rdata;

    always @(posedge clk) begin
        if (reset) begin
            r_sp    <= 0;
            r_rdata <= '0;
        end else if (stk_push) begin
            r_mem[r_sp % CAP] <= stk_wdata;
            r_sp              <= r_sp + 1;
        end else if (stk_pop) begin
            r_rdata <= r_mem[(r_sp + CAP - 1) % CAP];
            r_sp    <= r_sp - 1;
        end
    end

    // Reference model state
    int            m_pc;
    int            m_stack[$];
    bit            m_ovf, m_udf;
    bit            m_wait;
    int            m_ret;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Apply one cycle of inputs, compare DUT with model, then advance the model.
    task automatic step(input bit r, input bit v, input logic [1:0] o,
                        input int t, input bit s, input bit c);
        bit e_push, e_pop, e_busy, acc;
        int e_wdata;
        @(negedge clk);
        reset = r; op_valid = v; op = o; target = AW'(t); stall = s; err_clr = c;
        #1;
        check_val("pc",        pc,        32'(m_pc));
        check_val("depth",     depth,     32'(m_stack.size()));
        check_val("overflow",  overflow,  32'(m_ovf));
        check_val("underflow", underflow, 32'(m_udf));

        acc     = !r && !m_wait && v && !s;
        e_busy  = !r && m_wait;
        e_push  = acc && o == CALL && m_stack.size() < CAP;
        e_pop   = acc && o == RET  && m_stack.size() > 0;
        e_wdata = e_push ? (m_pc + 1) % (1 << AW) : 0;
        check_val("busy",      busy,      32'(e_busy));
        check_val("stk_push",  stk_push,  32'(e_push));
        check_val("stk_pop",   stk_pop,   32'(e_pop));
        check_val("stk_wdata", stk_wdata, 32'(e_wdata));

        if (r) begin
            m_pc = 0; m_stack.delete(); m_ovf = 0; m_udf = 0; m_wait = 0;
        end else begin
            if (c) begin m_ovf = 0; m_udf = 0; end
            if (m_wait) begin
                m_pc = m_ret; m_wait = 0;
            end else if (acc) begin
                case (o)
                    SEQ:  m_pc = (m_pc + 1) % (1 << AW);
                    JUMP: m_pc = t % (1 << AW);
                    CALL: if (m_stack.size() < CAP) begin
                              m_stack.push_back((m_pc + 1) % (1 << AW));
                              m_pc = t % (1 << AW);
                          end else begin
                              m_ovf = 1; m_pc = (m_pc + 1) % (1 << AW);
                          end
                    default: if (m_stack.size() > 0) begin
                              m_ret = m_stack.pop_back(); m_wait = 1;
                          end else begin
                              m_udf = 1; m_pc = (m_pc + 1) % (1 << AW);
                          end
                endcase
            end
        end
    endtask

    task automatic after_edge;
        @(posedge clk); #1;
    endtask

    int prev_pc;

    initial begin
        m_pc = 0; m_ovf = 0; m_udf = 0; m_wait = 0; m_ret = 0;
        repeat (2) @(posedge clk);

        // Reset state and three sequential steps
        step(1, 0, SEQ, 0, 0, 0);
        after_edge();
        check_val("rst_pc", pc, 0);
        check_val("rst_depth", depth, 0);
        repeat (3) step(0, 1, SEQ, 0, 0, 0);
        after_edge();
        check_val("seq3_pc", pc, 3);

        // Call then return
        step(1, 0, SEQ, 0, 0, 0);
        step(0, 1, JUMP, 'h005, 0, 0);
        step(0, 1, CALL, 'h100, 0, 0);
        check_val("call_push", stk_push, 1);
        check_val("call_wdata", stk_wdata, 'h006);
        after_edge();
        check_val("call_pc", pc, 'h100);
        check_val("call_depth", depth, 1);
        step(0, 1, RET, 0, 0, 0);
        check_val("ret_pop", stk_pop, 1);
        step(0, 1, SEQ, 0, 0, 0);
        check_val("ret_busy", busy, 1);
        after_edge();
        check_val("ret_pc", pc, 'h006);
        check_val("ret_depth", depth, 0);

        // Nine nested calls: the last overflows
        step(1, 0, SEQ, 0, 0, 0);
        for (int i = 0; i < CAP; i++) step(0, 1, CALL, 'h200 + i * 16, 0, 0);
        prev_pc = m_pc;
        step(0, 1, CALL, 'h0AA, 0, 0);
        check_val("ovf_nopush", stk_push, 0);
        after_edge();
        check_val("ovf_flag", overflow, 1);
        check_val("ovf_pc", pc, 32'(prev_pc + 1));
        check_val("ovf_depth", depth, CAP);
        for (int i = 0; i < CAP; i++) begin
            step(0, 1, RET, 0, 0, 0);
            step(0, 1, SEQ, 0, 0, 0);
        end

        // Underflow and clear
        step(1, 0, SEQ, 0, 0, 0);
        step(0, 1, JUMP, 'h010, 0, 0);
        step(0, 1, RET, 0, 0, 0);
        check_val("udf_nopop", stk_pop, 0);
        after_edge();
        check_val("udf_flag", underflow, 1);
        check_val("udf_pc", pc, 'h011);
        step(0, 0, SEQ, 0, 0, 1);
        after_edge();
        check_val("udf_clr", underflow, 0);

        // Stalled call
        repeat (3) step(0, 1, CALL, 'h0C0, 1, 0);
        step(0, 1, CALL, 'h0C0, 0, 0);
        check_val("stall_push", stk_push, 1);

        // Wrap-around and reset during RET_WAIT
        step(1, 0, SEQ, 0, 0, 0);
        step(0, 1, JUMP, 'h1FFF, 0, 0);
        step(0, 1, SEQ, 0, 0, 0);
        after_edge();
        check_val("wrap_pc", pc, 0);
        step(0, 1, JUMP, 'h1FFF, 0, 0);
        step(0, 1, CALL, 'h0300, 0, 0);
        check_val("wrap_wdata", stk_wdata, 0);
        step(0, 1, RET, 0, 0, 0);
        step(1, 1, SEQ, 0, 0, 0);
        after_edge();
        check_val("rstwait_pc", pc, 0);
        check_val("rstwait_busy", busy, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0,
                 2'($urandom_range(0, 3)), int'($urandom_range(0, (1 << AW) - 1)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_call_return_sequencer
`default_nettype wire
